// File: rtl/seg_pkg.sv
// Shared types and default timing constants for the board-level push-button
// conditioner.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } pb_state_t;

  // 20 ms debounce window and 2 s long-press threshold at 50 MHz.
  localparam int PB_DB_CYCLES   = 1_000_000;
  localparam int PB_LONG_CYCLES = 100_000_000;

endpackage : seg_pkg

// File: rtl/pb_sync.sv
// Two-flop synchronizer for a single asynchronous input. On reset both flops
// load RESET_VAL.
module pb_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic synced
);

  logic meta;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the value its input had before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= RESET_VAL;
      synced <= RESET_VAL;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule : pb_sync

// File: rtl/pb_debounce.sv
// Push-button conditioner: synchronizes the active-low button, debounces press
// and release, and reports a clean level plus press, release and long-press events.
module pb_debounce
  import seg_pkg::*;
#(
  parameter int DB_CYCLES   = PB_DB_CYCLES,
  parameter int LONG_CYCLES = PB_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB_n,
  output logic pb_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic long_flag
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              pb_raw_sync;
  logic              pb_sync;
  pb_state_t         state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_next;
  logic              level_d, flag_d, press_d, release_d, long_d;
  logic              long_hit;

  // Synchronizer powers up as "released" so a reset never looks like a press edge.
  pb_sync #(
    .RESET_VAL(1'b1)
  ) u_pb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (PB_n),
    .synced(pb_raw_sync)
  );

  assign pb_sync = ~pb_raw_sync;

  // The hold counter parks at HOLD_LAST; long_flag keeps the threshold from re-firing.
  assign hold_next = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1;
  assign long_hit  = (hold_cnt_q == HOLD_LAST) && !long_flag;

  // NOTE: every variable driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = pb_level;
    flag_d     = long_flag;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pb_sync) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end

      PRESS_DB: begin
        if (!pb_sync) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = HELD;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          press_d    = 1'b1;
          level_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      HELD: begin
        hold_cnt_d = hold_next;
        if (long_hit) begin
          long_d = 1'b1;
          flag_d = 1'b1;
        end
        if (!pb_sync) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
      end

      RELEASE_DB: begin
        hold_cnt_d = hold_next;
        // A completed release takes priority over a coincident long threshold.
        if (!pb_sync && db_cnt_q == DB_LAST) begin
          state_d   = IDLE;
          db_cnt_d  = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
          flag_d    = 1'b0;
        end else begin
          if (long_hit) begin
            long_d = 1'b1;
            flag_d = 1'b1;
          end
          if (pb_sync) begin
            state_d  = HELD;
            db_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      pb_level      <= 1'b0;
      long_flag     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      pb_level      <= level_d;
      long_flag     <= flag_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
    end
  end

endmodule : pb_debounce
